// File: rtl/piece_controller.sv
// piece_controller: drives the falling tetromino and the transmitting side of the board piece-lock handshake.
// Each candidate move is checked for collision against the live board before it is accepted.
module piece_controller #(
    parameter int SPAWN_ROW     = 18,
    parameter int SPAWN_COL     = 4,
    parameter int LOCK_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         refreshClock,
    input  logic         reset,
    input  logic         tick,
    input  logic         moveLeft,
    input  logic         moveRight,
    input  logic         rotate,
    input  logic         drop,
    input  logic [2:0]   newType,
    input  logic [199:0] board,
    output logic         setSignal,
    output logic [15:0]  setSpace,
    output logic [4:0]   setRow,
    output logic [3:0]   setCol,
    output logic [2:0]   blockType_out,
    output logic         gameOver
);
    typedef enum logic [2:0] {SPAWN, FALL, LOCK, SETTLE, OVER} state_t;
    state_t state, state_n;
    logic [7:0] counter, counter_n;
    logic drop_mode, drop_mode_n;
    logic [15:0] space_n, spawn_mask, rot_mask;
    logic [4:0] row_n;
    logic [3:0] col_n;
    logic [2:0] type_n, spawn_type;
    logic signed [5:0] row_s, col_s;
    logic down_free, left_free, right_free, rot_free, spawn_hit;

    function automatic logic [15:0] rot_cw(input logic [15:0] m);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[k[3:0]] = m[{k[1:0], ~k[3:2]}];
        return r;
    endfunction

    // Signed coordinates keep anchor-2 offsets from wrapping into valid cells.
    function automatic logic collides(input logic [15:0] m, input logic signed [5:0] r0,
                                      input logic signed [5:0] c0, input logic [199:0] b);
        logic signed [5:0] r, c;
        logic [7:0] idx;
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            r = r0 + $signed({4'b0, k[3:2]}) - 6'sd2;
            c = c0 + $signed({4'b0, k[1:0]}) - 6'sd2;
            idx = {2'b0, r} * 8'd10 + {2'b0, c};
            if (m[k[3:0]] && (r[5] || r > 6'sd19 || c[5] || c > 6'sd9 || b[idx]))
                hit = 1'b1;
        end
        return hit;
    endfunction

    assign spawn_type = newType == 3'd7 ? 3'd0 : newType;
    assign spawn_mask = spawn_type == 3'd1 ? 16'h00F0 :
                        spawn_type == 3'd2 ? 16'h0630 :
                        spawn_type == 3'd3 ? 16'h0360 :
                        spawn_type == 3'd4 ? 16'h0470 :
                        spawn_type == 3'd5 ? 16'h0170 :
                        spawn_type == 3'd6 ? 16'h0270 : 16'h0660;
    assign rot_mask   = rot_cw(setSpace);
    assign row_s      = $signed({1'b0, setRow});
    assign col_s      = $signed({2'b0, setCol});
    assign down_free  = !collides(setSpace, row_s - 6'sd1, col_s, board);
    assign left_free  = !collides(setSpace, row_s, col_s - 6'sd1, board);
    assign right_free = !collides(setSpace, row_s, col_s + 6'sd1, board);
    assign rot_free   = !collides(rot_mask, row_s, col_s, board);
    assign spawn_hit  = collides(spawn_mask, 6'(SPAWN_ROW), 6'(SPAWN_COL), board);
    assign setSignal  = state == LOCK;
    assign gameOver   = state == OVER;

    always_comb begin
        state_n     = state;
        counter_n   = counter;
        drop_mode_n = drop_mode;
        space_n     = setSpace;
        row_n       = setRow;
        col_n       = setCol;
        type_n      = blockType_out;
        case (state)
            SETTLE: begin
                counter_n = counter == 8'(SETTLE_CYCLES - 1) ? 8'd0 : counter + 8'd1;
                state_n   = counter == 8'(SETTLE_CYCLES - 1) ? SPAWN : SETTLE;
            end
            SPAWN: begin
                type_n      = spawn_type;
                space_n     = spawn_mask;
                row_n       = 5'(SPAWN_ROW);
                col_n       = 4'(SPAWN_COL);
                drop_mode_n = 1'b0;
                state_n     = spawn_hit ? OVER : FALL;
            end
            FALL: begin
                // One action per cycle; lower-priority pulses in the same cycle are lost.
                if (drop_mode) begin
                    if (down_free) row_n = setRow - 5'd1;
                    else state_n = LOCK;
                end else if (drop) begin
                    drop_mode_n = 1'b1;
                end else if (rotate) begin
                    if (rot_free) space_n = rot_mask;
                end else if (moveLeft) begin
                    if (left_free) col_n = setCol - 4'd1;
                end else if (moveRight) begin
                    if (right_free) col_n = setCol + 4'd1;
                end else if (tick) begin
                    if (down_free) row_n = setRow - 5'd1;
                    else state_n = LOCK;
                end
            end
            LOCK: begin
                counter_n = counter == 8'(LOCK_CYCLES - 1) ? 8'd0 : counter + 8'd1;
                state_n   = counter == 8'(LOCK_CYCLES - 1) ? SETTLE : LOCK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge refreshClock or posedge reset) begin
        if (reset) begin
            state         <= SETTLE;
            counter       <= '0;
            drop_mode     <= 1'b0;
            setSpace      <= '0;
            setRow        <= '0;
            setCol        <= '0;
            blockType_out <= '0;
        end else begin
            state         <= state_n;
            counter       <= counter_n;
            drop_mode     <= drop_mode_n;
            setSpace      <= space_n;
            setRow        <= row_n;
            setCol        <= col_n;
            blockType_out <= type_n;
        end
    end
endmodule

// File: tb/tb_piece_controller.sv
// tb_piece_controller: directed and random stimulus against a cell-list reference model of the piece controller.
module tb_piece_controller;
    localparam int LOCK_CYCLES = 4, SETTLE_CYCLES = 4;
    localparam int PH_SETTLE = 0, PH_SPAWN = 1, PH_FALL = 2, PH_LOCK = 3, PH_OVER = 4;

    logic refreshClock = 1'b0, reset = 1'b0;
    logic tick = 1'b0, moveLeft = 1'b0, moveRight = 1'b0, rotate = 1'b0, drop = 1'b0;
    logic [2:0] newType = 3'd1;
    logic [199:0] board = '0;
    logic setSignal, gameOver;
    logic [15:0] setSpace;
    logic [4:0] setRow;
    logic [3:0] setCol;
    logic [2:0] blockType_out;

    int checks = 0, failures = 0;
    int m_phase, m_left, m_row, m_col, m_type;
    bit m_drop, m_has;
    int ci[4], cj[4];
    logic [15:0] shapes [8] = '{16'h0660, 16'h00F0, 16'h0630, 16'h0360,
                                16'h0470, 16'h0170, 16'h0270, 16'h0660};

    piece_controller dut (
        .refreshClock(refreshClock), .reset(reset), .tick(tick), .moveLeft(moveLeft),
        .moveRight(moveRight), .rotate(rotate), .drop(drop), .newType(newType), .board(board),
        .setSignal(setSignal), .setSpace(setSpace), .setRow(setRow), .setCol(setCol),
        .blockType_out(blockType_out), .gameOver(gameOver)
    );

    always #5 refreshClock = ~refreshClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {2'b0, setSignal, setSpace, setRow, setCol, blockType_out, gameOver};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [15:0] m;
        m = '0;
        if (m_has)
            for (int k = 0; k < 4; k++) m[ci[k] * 4 + cj[k]] = 1'b1;
        return {2'b0, m_phase == PH_LOCK, m, 5'(m_row), 4'(m_col), 3'(m_type), m_phase == PH_OVER};
    endfunction

    function automatic bit fits(input int ai[4], input int aj[4], input int row, input int col);
        int r, c;
        for (int k = 0; k < 4; k++) begin
            r = row + ai[k] - 2;
            c = col + aj[k] - 2;
            if (r < 0 || r > 19 || c < 0 || c > 9) return 1'b0;
            if (board[r * 10 + c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = PH_SETTLE;
        m_left  = SETTLE_CYCLES;
        m_has   = 1'b0;
        m_drop  = 1'b0;
        m_row   = 0;
        m_col   = 0;
        m_type  = 0;
    endtask

    task automatic model_step();
        int n, ni[4], nj[4];
        case (m_phase)
            PH_SETTLE: begin
                m_left--;
                if (m_left == 0) m_phase = PH_SPAWN;
            end
            PH_SPAWN: begin
                n = 0;
                for (int b = 0; b < 16; b++)
                    if (shapes[newType][b]) begin ci[n] = b / 4; cj[n] = b % 4; n++; end
                m_type  = newType == 3'd7 ? 0 : int'(newType);
                m_row   = 18;
                m_col   = 4;
                m_drop  = 1'b0;
                m_has   = 1'b1;
                m_phase = fits(ci, cj, m_row, m_col) ? PH_FALL : PH_OVER;
            end
            PH_FALL: begin
                if (m_drop || (!drop && !rotate && !moveLeft && !moveRight && tick)) begin
                    if (fits(ci, cj, m_row - 1, m_col)) m_row--;
                    else begin m_phase = PH_LOCK; m_left = LOCK_CYCLES; end
                end else if (drop) begin
                    m_drop = 1'b1;
                end else if (rotate) begin
                    for (int k = 0; k < 4; k++) begin ni[k] = 3 - cj[k]; nj[k] = ci[k]; end
                    if (fits(ni, nj, m_row, m_col)) begin ci = ni; cj = nj; end
                end else if (moveLeft) begin
                    if (fits(ci, cj, m_row, m_col - 1)) m_col--;
                end else if (moveRight) begin
                    if (fits(ci, cj, m_row, m_col + 1)) m_col++;
                end
            end
            PH_LOCK: begin
                m_left--;
                if (m_left == 0) begin m_phase = PH_SETTLE; m_left = SETTLE_CYCLES; end
            end
            default: ;
        endcase
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge refreshClock);
        #1;
        check(tag, dut_vec(), model_vec());
        {tick, moveLeft, moveRight, rotate, drop} = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        #1 check(tag, dut_vec(), model_vec());
        @(posedge refreshClock);
        #1 reset = 1'b0;
    endtask

    task automatic rand_board();
        int h;
        board = '0;
        h = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(0, 12);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < 10; c++)
                board[r * 10 + c] = ($urandom_range(0, 9) < 4);
    endtask

    initial begin
        int hi, lo, over_cnt;
        int left_exp[4] = '{3, 2, 1, 1};
        logic [31:0] held;

        do_reset("reset");
        check("reset_zero", dut_vec(), 32'h0);
        for (int i = 0; i < 4; i++) step("settle");
        check("pre_spawn_space", setSpace, 16'h0);
        step("spawn");
        check("spawn_space", setSpace, 16'h00F0);
        check("spawn_row", setRow, 18);
        check("spawn_col", setCol, 4);
        check("spawn_type", blockType_out, 1);

        drop = 1'b1;
        step("drop");
        check("drop_no_move", setRow, 18);
        for (int i = 0; i < 40 && !setSignal; i++) step("fall");
        check("lock_seen", setSignal, 1);
        check("lock_row", setRow, 1);
        hi = 0;
        for (int i = 0; i < 20 && setSignal; i++) begin hi++; step("lock"); end
        check("lock_len", hi, LOCK_CYCLES);
        lo = 0;
        for (int i = 0; i < 20 && setRow != 5'd18; i++) begin lo++; step("settle"); end
        check("settle_len", lo, SETTLE_CYCLES + 1);

        newType = 3'd0;
        do_reset("reset_o");
        for (int i = 0; i < 5; i++) step("spawn_o");
        check("o_space", setSpace, 16'h0660);
        for (int k = 0; k < 4; k++) begin
            moveLeft = 1'b1;
            step("left");
            check("left_col", setCol, left_exp[k]);
        end
        tick = 1'b1;
        moveRight = 1'b1;
        step("tick_right");
        check("tr_col", setCol, 2);
        check("tr_row", setRow, 18);

        newType = 3'd6;
        do_reset("reset_t");
        for (int i = 0; i < 5; i++) step("spawn_t");
        board[162 +: 4] = 4'hF;
        tick = 1'b1;
        step("t_tick");
        check("t_lock", setSignal, 1);
        check("t_lock_row", setRow, 18);
        step("t_lock2");
        check("t_lock_hold", setSignal, 1);
        do_reset("lock_async_reset");

        board = '0;
        board[199:160] = '1;
        newType = 3'd7;
        for (int i = 0; i < 5; i++) step("spawn_over");
        check("over_flag", gameOver, 1);
        held = dut_vec();
        for (int i = 0; i < 4; i++) begin
            {tick, moveLeft, moveRight, rotate, drop} = 5'($urandom_range(1, 31));
            step("over_pulses");
            check("over_hold", dut_vec(), held);
        end
        board = '0;
        do_reset("over_reset");
        check("over_cleared", gameOver, 0);

        over_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) rand_board();
            newType   = 3'($urandom_range(0, 7));
            tick      = ($urandom_range(0, 3) == 0);
            moveLeft  = ($urandom_range(0, 5) == 0);
            moveRight = ($urandom_range(0, 5) == 0);
            rotate    = ($urandom_range(0, 5) == 0);
            drop      = ($urandom_range(0, 29) == 0);
            step("rand");
            if (m_phase == PH_OVER) over_cnt++;
            if (over_cnt > 3) begin
                over_cnt = 0;
                do_reset("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
